sram_like_arbiter: RTL and testbench

//  Parametrised N-channel arbiter for the SRAM-like bus (req/addr_ok/data_ok).

---
 rtl/sram_like_pkg.sv | 14 +
 rtl/sram_like_id_fifo.sv | 43 ++++
 rtl/sram_like_arbiter.sv | 82 ++++++++
 tb/tb_sram_like_arbiter.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/sram_like_pkg.sv
// sram_like_pkg: shared SRAM-like bus constants, request-field widths and ID width helper.
package sram_like_pkg;
    localparam logic [1:0] SIZE_BYTE = 2'd0;
    localparam logic [1:0] SIZE_HALF = 2'd1;
    localparam logic [1:0] SIZE_WORD = 2'd2;
    localparam int BUS_AW = 32;
    localparam int BUS_DW = 32;
    localparam int BUS_SW = BUS_DW / 8;
    // wr + size + wstrb + addr + wdata, as carried by the if/exe stage request bundles
    localparam int REQ_W = 1 + 2 + BUS_SW + BUS_AW + BUS_DW;
    function automatic int id_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction
endpackage

// File: rtl/sram_like_id_fifo.sv
// sram_like_id_fifo: synchronous FIFO of channel IDs awaiting their data_ok.
module sram_like_id_fifo #(
    parameter int DEPTH = 4,
    parameter int W = 1
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] din,
    output logic         full,
    output logic         empty,
    output logic [W-1:0] head
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH) + 1;
    logic [W-1:0]  r_mem [DEPTH];
    logic [PW-1:0] r_wp, r_rp;
    logic [CW-1:0] r_cnt;
    logic          w_push, w_pop;
    function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction
    assign full   = r_cnt == CW'(DEPTH);
    assign empty  = r_cnt == '0;
    assign head   = r_mem[r_rp];
    assign w_push = push & ~full;
    assign w_pop  = pop & ~empty;
    always_ff @(posedge clk) begin
        if (reset) begin
            r_wp  <= '0;
            r_rp  <= '0;
            r_cnt <= '0;
        end else begin
            if (w_push) begin
                r_mem[r_wp] <= din;
                r_wp        <= nxt(r_wp);
            end
            if (w_pop) r_rp <= nxt(r_rp);
            r_cnt <= r_cnt + CW'(w_push) - CW'(w_pop);
        end
    end
endmodule

// File: rtl/sram_like_arbiter.sv
// sram_like_arbiter: merges NCH SRAM-like channels onto one port and routes
// each data_ok back to its issuing channel in acceptance order.
module sram_like_arbiter
    import sram_like_pkg::*;
#(
    parameter int NCH   = 2,
    parameter int AW    = BUS_AW,
    parameter int DW    = BUS_DW,
    parameter int OUTST = 4,
    parameter int RR    = 0
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [NCH-1:0]      ch_req,
    input  logic [NCH-1:0]      ch_wr,
    input  logic [2*NCH-1:0]    ch_size,
    input  logic [DW/8*NCH-1:0] ch_wstrb,
    input  logic [AW*NCH-1:0]   ch_addr,
    input  logic [DW*NCH-1:0]   ch_wdata,
    output logic [NCH-1:0]      ch_addr_ok,
    output logic [NCH-1:0]      ch_data_ok,
    output logic [DW-1:0]       ch_rdata,
    output logic                mem_req,
    output logic                mem_wr,
    output logic [1:0]          mem_size,
    output logic [DW/8-1:0]     mem_wstrb,
    output logic [AW-1:0]       mem_addr,
    output logic [DW-1:0]       mem_wdata,
    input  logic                mem_addr_ok,
    input  logic                mem_data_ok,
    input  logic [DW-1:0]       mem_rdata
);
    localparam int SW  = DW / 8;
    localparam int IDW = id_width(NCH);
    logic [IDW-1:0] r_lock_id, r_ptr, w_pick, w_gnt, w_head;
    logic           r_lock, w_full, w_empty, w_hs, w_pop;
    // Round-robin scans offsets downward so the smallest offset from r_ptr wins last.
    always_comb begin
        w_pick = '0;
        if (RR == 0) begin
            for (int i = 0; i < NCH; i++) if (ch_req[i]) w_pick = IDW'(i);
        end else begin
            for (int i = NCH - 1; i >= 0; i--)
                if (ch_req[(int'(r_ptr) + i) % NCH]) w_pick = IDW'((int'(r_ptr) + i) % NCH);
        end
    end
    assign w_gnt      = r_lock ? r_lock_id : w_pick;
    assign mem_req    = |ch_req & ~w_full & ~reset;
    assign w_hs       = mem_req & mem_addr_ok;
    assign w_pop      = mem_data_ok & ~w_empty & ~reset;
    assign mem_wr     = ch_wr[w_gnt];
    assign mem_size   = ch_size[2*int'(w_gnt) +: 2];
    assign mem_wstrb  = ch_wstrb[SW*int'(w_gnt) +: SW];
    assign mem_addr   = ch_addr[AW*int'(w_gnt) +: AW];
    assign mem_wdata  = ch_wdata[DW*int'(w_gnt) +: DW];
    assign ch_addr_ok = w_hs ? NCH'(1) << w_gnt : '0;
    assign ch_data_ok = w_pop ? NCH'(1) << w_head : '0;
    assign ch_rdata   = mem_rdata;
    always_ff @(posedge clk) begin
        if (reset) begin
            r_lock    <= 1'b0;
            r_lock_id <= '0;
            r_ptr     <= '0;
        end else begin
            r_lock <= mem_req & ~mem_addr_ok;
            if (mem_req & ~mem_addr_ok) r_lock_id <= w_gnt;
            if (w_hs) r_ptr <= (w_gnt == IDW'(NCH - 1)) ? '0 : w_gnt + 1'b1;
        end
    end
    sram_like_id_fifo #(.DEPTH(OUTST), .W(IDW)) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (w_hs),
        .pop   (w_pop),
        .din   (w_gnt),
        .full  (w_full),
        .empty (w_empty),
        .head  (w_head)
    );
    a_no_stray_data_ok: assert property (@(posedge clk) disable iff (reset) !(mem_data_ok && w_empty));
    a_lock_holds_req: assert property (@(posedge clk) disable iff (reset) r_lock |-> ch_req[r_lock_id]);
endmodule

// File: tb/tb_sram_like_arbiter.sv
// tb_sram_like_arbiter: directed and random checks of a 2-channel fixed-priority
// and a 3-channel round-robin arbiter against a queue-based reference model.
module tb_sram_like_arbiter;
    localparam int OUTST = 4;
    logic clk = 1'b0;
    logic rst;
    logic [1:0][2:0]  req, wr;
    logic [1:0][5:0]  size;
    logic [1:0][11:0] wstrb;
    logic [1:0][95:0] addr, wdata;
    logic [1:0]       maok, mdok;
    logic [1:0][31:0] mrdata;
    logic [1:0]       aok0, dok0;
    logic [2:0]       aok1, dok1;
    logic [1:0][31:0] rd, ma, mwd;
    logic [1:0]       mreq, mwr;
    logic [1:0][1:0]  msz;
    logic [1:0][3:0]  mws;
    logic [1:0][2:0]  o_aok, o_dok;
    int n_vec = 0;
    int n_bad = 0;
    int q [2][$];
    int held [2];
    int ptr [2];
    assign o_aok[0] = {1'b0, aok0};
    assign o_aok[1] = aok1;
    assign o_dok[0] = {1'b0, dok0};
    assign o_dok[1] = dok1;
    always #5 clk = ~clk;

    sram_like_arbiter #(.NCH(2), .OUTST(OUTST), .RR(0)) dut0 (
        .clk(clk), .reset(rst), .ch_req(req[0][1:0]), .ch_wr(wr[0][1:0]), .ch_size(size[0][3:0]),
        .ch_wstrb(wstrb[0][7:0]), .ch_addr(addr[0][63:0]), .ch_wdata(wdata[0][63:0]),
        .ch_addr_ok(aok0), .ch_data_ok(dok0), .ch_rdata(rd[0]), .mem_req(mreq[0]), .mem_wr(mwr[0]),
        .mem_size(msz[0]), .mem_wstrb(mws[0]), .mem_addr(ma[0]), .mem_wdata(mwd[0]),
        .mem_addr_ok(maok[0]), .mem_data_ok(mdok[0]), .mem_rdata(mrdata[0])
    );
    sram_like_arbiter #(.NCH(3), .OUTST(OUTST), .RR(1)) dut1 (
        .clk(clk), .reset(rst), .ch_req(req[1]), .ch_wr(wr[1]), .ch_size(size[1]),
        .ch_wstrb(wstrb[1]), .ch_addr(addr[1]), .ch_wdata(wdata[1]),
        .ch_addr_ok(aok1), .ch_data_ok(dok1), .ch_rdata(rd[1]), .mem_req(mreq[1]), .mem_wr(mwr[1]),
        .mem_size(msz[1]), .mem_wstrb(mws[1]), .mem_addr(ma[1]), .mem_wdata(mwd[1]),
        .mem_addr_ok(maok[1]), .mem_data_ok(mdok[1]), .mem_rdata(mrdata[1])
    );

    task automatic chk(input string tag, input logic [95:0] got, input logic [95:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    // Held channel first; otherwise instance 0 takes the highest index, instance 1 the first at/after ptr.
    function automatic int grant(input int k);
        int n = k ? 3 : 2;
        if (held[k] >= 0) return held[k];
        if (k == 0) begin
            for (int i = n - 1; i >= 0; i--) if (req[k][i]) return i;
        end else begin
            for (int j = 0; j < n; j++) if (req[k][(ptr[k] + j) % n]) return (ptr[k] + j) % n;
        end
        return 0;
    endfunction

    task automatic step();
        int g [2];
        bit push [2], pop [2], lock [2];
        #1;
        for (int k = 0; k < 2; k++) begin
            logic [2:0] mask = k ? 3'b111 : 3'b011;
            bit exp_req = !rst && |(req[k] & mask) && q[k].size() < OUTST;
            g[k]    = grant(k);
            pop[k]  = !rst && mdok[k] && q[k].size() > 0;
            push[k] = exp_req && maok[k];
            lock[k] = exp_req && !maok[k];
            chk($sformatf("mem_req[%0d]", k), 96'(mreq[k]), 96'(exp_req));
            if (exp_req) begin
                chk($sformatf("mem_addr[%0d]", k), 96'(ma[k]), 96'(addr[k][g[k]*32 +: 32]));
                chk($sformatf("mem_wdata[%0d]", k), 96'(mwd[k]), 96'(wdata[k][g[k]*32 +: 32]));
                chk($sformatf("mem_ctl[%0d]", k), 96'({mwr[k], msz[k], mws[k]}),
                    96'({wr[k][g[k]], size[k][g[k]*2 +: 2], wstrb[k][g[k]*4 +: 4]}));
            end
            chk($sformatf("ch_addr_ok[%0d]", k), 96'(o_aok[k]), push[k] ? 96'(1) << g[k] : 96'(0));
            chk($sformatf("ch_data_ok[%0d]", k), 96'(o_dok[k]), pop[k] ? 96'(1) << q[k][0] : 96'(0));
            if (pop[k]) chk($sformatf("ch_rdata[%0d]", k), 96'(rd[k]), 96'(mrdata[k]));
        end
        @(posedge clk);
        for (int k = 0; k < 2; k++) begin
            if (rst) begin
                q[k].delete();
                held[k] = -1;
                ptr[k]  = 0;
            end else begin
                if (pop[k]) void'(q[k].pop_front());
                if (push[k]) begin
                    q[k].push_back(g[k]);
                    ptr[k] = (g[k] + 1) % (k ? 3 : 2);
                end
                held[k] = lock[k] ? g[k] : -1;
            end
        end
        @(negedge clk);
    endtask

    task automatic idle(input int k);
        req[k]  = '0;
        maok[k] = 1'b0;
        mdok[k] = 1'b0;
    endtask

    task automatic rnd_fields(input int k);
        wr[k]     = 3'($urandom);
        size[k]   = 6'($urandom);
        wstrb[k]  = 12'($urandom);
        addr[k]   = {$urandom, $urandom, $urandom};
        wdata[k]  = {$urandom, $urandom, $urandom};
        mrdata[k] = $urandom;
    endtask

    initial begin
        held = '{-1, -1};
        ptr  = '{0, 0};
        rst  = 1'b1;
        for (int k = 0; k < 2; k++) begin
            rnd_fields(k);
            req[k] = 3'b111;
            maok[k] = 1'b1;
            mdok[k] = 1'b1;
        end
        @(negedge clk);
        #1 chk("reset_outputs", 96'({mreq, o_aok, o_dok}), 96'(0));
        step();
        step();
        rst = 1'b0;
        idle(0);
        idle(1);
        // ch0 and ch1 together on fixed priority; round-robin rotation on the 3-channel instance
        for (int i = 0; i < 6; i++) begin
            req[1] = 3'b111;
            maok[1] = 1'b1;
            mdok[1] = q[1].size() > 0;
            req[0] = (i == 0) ? 3'b011 : (i == 1) ? 3'b001 : 3'b000;
            maok[0] = i < 2;
            mdok[0] = (i == 2 || i == 3);
            #1 chk("rr_rotate", 96'(aok1), 96'(1) << (i % 3));
            if (i == 0) chk("prio_both", 96'(aok0), 96'(2'b10));
            if (i == 1) chk("prio_ch0_next", 96'(aok0), 96'(2'b01));
            if (i == 2) chk("order_first", 96'(dok0), 96'(2'b10));
            if (i == 3) chk("order_second", 96'(dok0), 96'(2'b01));
            step();
        end
        idle(0);
        idle(1);
        // push+pop at count 2 on the round-robin instance
        req[1] = 3'b010;
        maok[1] = 1'b1;
        step();
        req[1] = 3'b001;
        mdok[1] = 1'b1;
        #1 chk("pushpop_aok", 96'(aok1), 96'(3'b001));
        chk("pushpop_dok", 96'(dok1), 96'(3'b100));
        step();
        req[1] = '0;
        #1 chk("pushpop_next", 96'(dok1), 96'(3'b010));
        step();
        #1 chk("pushpop_last", 96'(dok1), 96'(3'b001));
        step();
        idle(1);
        // lock: ch0 stalls, ch1 joins late and must wait
        addr[0][31:0]  = 32'h0000_00A0;
        addr[0][63:32] = 32'h0000_00B1;
        for (int i = 0; i < 5; i++) begin
            req[0] = (i == 0) ? 3'b001 : (i == 4) ? 3'b010 : 3'b011;
            maok[0] = i >= 3;
            #1;
            if (i < 4) chk("lock_addr", 96'(ma[0]), 96'(32'hA0));
            if (i < 3) chk("lock_wait", 96'(aok0), 96'(0));
            if (i == 3) chk("lock_release", 96'(aok0), 96'(2'b01));
            if (i == 4) chk("lock_ch1", 96'(aok0), 96'(2'b10));
            step();
        end
        idle(0);
        mdok[0] = 1'b1;
        step();
        step();
        idle(0);
        // fill to OUTST; a data_ok while full must not reopen mem_req until the next cycle
        req[0] = 3'b001;
        maok[0] = 1'b1;
        for (int i = 0; i < 4; i++) step();
        mdok[0] = 1'b1;
        #1 chk("full_req", 96'(mreq[0]), 96'(0));
        chk("full_dok", 96'(dok0), 96'(2'b01));
        step();
        mdok[0] = 1'b0;
        #1 chk("full_reopen", 96'(mreq[0]), 96'(1));
        step();
        // reset with outstanding IDs drops them
        rst = 1'b1;
        mdok[0] = 1'b1;
        #1 chk("rst_dok", 96'(dok0), 96'(0));
        step();
        rst = 1'b0;
        mdok[0] = 1'b0;
        for (int i = 0; i < 4; i++) begin
            #1 chk("post_rst_req", 96'(mreq[0]), 96'(1));
            step();
        end
        idle(0);
        for (int c = 0; c < 600; c++) begin
            for (int k = 0; k < 2; k++) begin
                rnd_fields(k);
                req[k] = 3'($urandom);
                if (held[k] >= 0) req[k][held[k]] = 1'b1;
                maok[k] = 1'($urandom);
                mdok[k] = q[k].size() > 0 && ($urandom_range(0, 2) != 0);
            end
            rst = ($urandom_range(0, 63) == 0);
            step();
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
